// File: rtl/alu_arbiter_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Purpose : Shared types and constants for the two-requester ALU arbiter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    // Opcode carried on each request channel
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_MUL = 2'b11
    } alu_op_t;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Requester identifiers as they appear on rsp_id
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_if.sv
// ============================================================================
// Module  : alu_arbiter_if
// Purpose : Request/response bundle between issue logic and the arbiter.
//           ALU_ARB_OVF_EN adds the rsp_ovf response bit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int N = 8
) ();

    logic          r0_valid;
    logic          r0_ready;
    alu_op_t       r0_op;
    logic [N-1:0]  r0_a;
    logic [N-1:0]  r0_b;

    logic          r1_valid;
    logic          r1_ready;
    alu_op_t       r1_op;
    logic [N-1:0]  r1_a;
    logic [N-1:0]  r1_b;

    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic [N-1:0]  rsp_data;
`ifdef ALU_ARB_OVF_EN
    logic          rsp_ovf;
`endif

    // Issue side / result consumer
    modport master (
        output r0_valid, r0_op, r0_a, r0_b,
        output r1_valid, r1_op, r1_a, r1_b,
        output rsp_ready,
        input  r0_ready, r1_ready,
        input  rsp_valid, rsp_id, rsp_data
`ifdef ALU_ARB_OVF_EN
        , input rsp_ovf
`endif
    );

    // Arbiter side
    modport slave (
        input  r0_valid, r0_op, r0_a, r0_b,
        input  r1_valid, r1_op, r1_a, r1_b,
        input  rsp_ready,
        output r0_ready, r1_ready,
        output rsp_valid, rsp_id, rsp_data
`ifdef ALU_ARB_OVF_EN
        , output rsp_ovf
`endif
    );

endinterface

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
// Module  : alu_core
// Purpose : Combinational N-bit ripple-carry adder plus bitwise AND.
//           SUB inverts b; the caller supplies the carry-in.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_core
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    input  alu_op_t      op,
    output logic [N-1:0] result,
    output logic         c_out
);

    logic [N-1:0] b_eff;
    logic [N-1:0] sum;
    logic [N:0]   carry;

    assign b_eff    = (op == ALU_SUB) ? ~b : b;
    assign carry[0] = c_in;

    // Full-adder ripple chain
    generate
        for (genvar i = 0; i < N; i++) begin : g_fa
            assign sum[i]     = a[i] ^ b_eff[i] ^ carry[i];
            assign carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
        end
    endgenerate

    assign result = (op == ALU_AND) ? (a & b) : sum;
    assign c_out  = carry[N];

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module  : alu_arbiter
// Purpose : Round-robin share of one ALU core between two requesters.
//           ADD/SUB/AND finish in one cycle; MUL runs N shift-add steps on
//           the same adder. One op in flight, one tagged response at a time.
//           Optional: ALU_ARB_OVF_EN adds rsp_ovf (signed ovf / MUL high bits).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    localparam int CW = $clog2(N);

    arb_state_t   state;
    arb_state_t   state_nxt;

    logic         ptr;
    logic         gnt_any;
    logic         gnt_id;
    alu_op_t      gnt_op;
    logic [N-1:0] gnt_a;
    logic [N-1:0] gnt_b;

    logic [N-1:0] mul_a;
    logic [N-1:0] mul_b;
    logic [N-1:0] acc;
    logic [CW-1:0] cnt;
    logic         last_iter;
    logic [N-1:0] partial;
    logic [N-1:0] addend;

    logic [N-1:0] core_a;
    logic [N-1:0] core_b;
    logic         core_cin;
    alu_op_t      core_op;
    logic [N-1:0] core_res;
    logic         core_cout;

    logic         rsp_id_q;
    logic [N-1:0] rsp_data_q;

    // Grant: a lone valid wins outright; a tie goes to the pointer
    always_comb begin
        gnt_any = bus.r0_valid | bus.r1_valid;
        gnt_id  = (bus.r0_valid & bus.r1_valid) ? ptr : bus.r1_valid;
        gnt_op  = gnt_id ? bus.r1_op : bus.r0_op;
        gnt_a   = gnt_id ? bus.r1_a  : bus.r0_a;
        gnt_b   = gnt_id ? bus.r1_b  : bus.r0_b;
    end

    assign last_iter = (cnt == CW'(N - 1));
    assign partial   = mul_a << cnt;
    assign addend    = mul_b[cnt] ? partial : '0;

    // Core operand mux: multiply accumulates in EXEC, otherwise the granted op
    always_comb begin
        if (state == EXEC) begin
            core_a   = acc;
            core_b   = addend;
            core_op  = ALU_ADD;
            core_cin = 1'b0;
        end else begin
            core_a   = gnt_a;
            core_b   = gnt_b;
            core_op  = gnt_op;
            core_cin = (gnt_op == ALU_SUB);
        end
    end

    alu_core #(.N(N)) u_core (
        .a      (core_a),
        .b      (core_b),
        .c_in   (core_cin),
        .op     (core_op),
        .result (core_res),
        .c_out  (core_cout)
    );

`ifdef ALU_ARB_OVF_EN
    logic [N-1:0]   hi_acc;
    logic [N-1:0]   hi_part;
    logic [N-1:0]   hi_nxt;
    logic [2*N-1:0] partial_wide;
    logic           b_eff_msb;
    logic           sc_ovf;
    logic           rsp_ovf_q;

    // High half of the shifted partial plus the low-half carry keeps the
    // full 2N-bit product without a second low-half adder
    always_comb begin
        partial_wide = {{N{1'b0}}, mul_a} << cnt;
        hi_part      = mul_b[cnt] ? partial_wide[2*N-1:N] : '0;
        hi_nxt       = hi_acc + hi_part + {{(N-1){1'b0}}, core_cout};
        b_eff_msb    = (gnt_op == ALU_SUB) ? ~gnt_b[N-1] : gnt_b[N-1];
        sc_ovf       = (gnt_op != ALU_AND) && (gnt_a[N-1] == b_eff_msb) &&
                       (core_res[N-1] != gnt_a[N-1]);
    end

    assign bus.rsp_ovf = rsp_ovf_q;
`else
    logic carry_unused;
    assign carry_unused = core_cout;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and request-side readies
    always_comb begin
        state_nxt    = state;
        bus.r0_ready = 1'b0;
        bus.r1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_any) begin
                    bus.r0_ready = (gnt_id == REQ0);
                    bus.r1_ready = (gnt_id == REQ1);
                    state_nxt    = (gnt_op == ALU_MUL) ? EXEC : RESP;
                end
            end
            EXEC: begin
                if (last_iter) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers: pointer, response tag/data and multiply state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= REQ0;
            rsp_id_q   <= REQ0;
            rsp_data_q <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            acc        <= '0;
            cnt        <= '0;
`ifdef ALU_ARB_OVF_EN
            hi_acc     <= '0;
            rsp_ovf_q  <= 1'b0;
`endif
        end else begin
            if (state == IDLE && gnt_any) begin
                ptr      <= ~gnt_id;
                rsp_id_q <= gnt_id;
                if (gnt_op == ALU_MUL) begin
                    mul_a <= gnt_a;
                    mul_b <= gnt_b;
                    acc   <= '0;
                    cnt   <= '0;
`ifdef ALU_ARB_OVF_EN
                    hi_acc <= '0;
`endif
                end else begin
                    rsp_data_q <= core_res;
`ifdef ALU_ARB_OVF_EN
                    rsp_ovf_q  <= sc_ovf;
`endif
                end
            end else if (state == EXEC) begin
                acc <= core_res;
                cnt <= cnt + CW'(1);
`ifdef ALU_ARB_OVF_EN
                hi_acc <= hi_nxt;
`endif
                if (last_iter) begin
                    rsp_data_q <= core_res;
`ifdef ALU_ARB_OVF_EN
                    rsp_ovf_q  <= |hi_nxt;
`endif
                end
            end
        end
    end

    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module  : tb_alu_arbiter
// Purpose : Directed-vector bench for alu_arbiter (N=8) with a response
//           scoreboard. Honors ALU_ARB_OVF_EN for the rsp_ovf checks.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk;
    logic rst_n;

    alu_arbiter_if #(.N(8)) bus ();

    alu_arbiter #(.N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic id, input logic v, input alu_op_t op,
                         input logic [7:0] a, input logic [7:0] b);
        if (id) begin
            bus.r1_valid = v; bus.r1_op = op; bus.r1_a = a; bus.r1_b = b;
        end else begin
            bus.r0_valid = v; bus.r0_op = op; bus.r0_a = a; bus.r0_b = b;
        end
    endtask

    task automatic expect_rsp(input logic id, input logic [7:0] d, input logic o);
        exp_t e;
        e.id = id; e.data = d; e.ovf = o;
        exp_q.push_back(e);
    endtask

    // Returns right after the accepting edge; waited = cycles until ready seen
    task automatic wait_accept(input logic id, output int waited);
        bit got;
        got = 1'b0;
        waited = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            waited++;
            if ((id ? bus.r1_ready : bus.r0_ready) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic measure_lat(output int lat);
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid === 1'b1) break;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare every response handshake against the queue
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_id", {31'd0, bus.rsp_id}, {31'd0, e.id});
                chk("rsp_data", {24'd0, bus.rsp_data}, {24'd0, e.data});
`ifdef ALU_ARB_OVF_EN
                chk("rsp_ovf", {31'd0, bus.rsp_ovf}, {31'd0, e.ovf});
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int lat;
        bit seen;

        rst_n         = 1'b0;
        bus.rsp_ready = 1'b0;
        drive(1'b0, 1'b0, ALU_ADD, 8'h00, 8'h00);
        drive(1'b1, 1'b0, ALU_ADD, 8'h00, 8'h00);

        // Reset state
        @(negedge clk);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_id",    {31'd0, bus.rsp_id},    32'd0);
        chk("rst_rsp_data",  {24'd0, bus.rsp_data},  32'd0);
        chk("rst_r0_ready",  {31'd0, bus.r0_ready},  32'd0);
        chk("rst_r1_ready",  {31'd0, bus.r1_ready},  32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("post_rst_rsp_data",  {24'd0, bus.rsp_data},  32'd0);
        @(posedge clk);
        #1;

        // r0 ADD 7F+01 = 80, signed overflow
        bus.rsp_ready = 1'b1;
        drive(1'b0, 1'b1, ALU_ADD, 8'h7F, 8'h01);
        expect_rsp(1'b0, 8'h80, 1'b1);
        wait_accept(1'b0, w);
        drive(1'b0, 1'b0, ALU_ADD, 8'h00, 8'h00);
        measure_lat(lat);
        chk("add_latency", lat, 32'd1);
        wait_drain();

        // r1 SUB 05-07 = FE held while rsp_ready low; r0 waits meanwhile
        bus.rsp_ready = 1'b0;
        drive(1'b1, 1'b1, ALU_SUB, 8'h05, 8'h07);
        expect_rsp(1'b1, 8'hFE, 1'b0);
        wait_accept(1'b1, w);
        drive(1'b1, 1'b0, ALU_ADD, 8'h00, 8'h00);
        drive(1'b0, 1'b1, ALU_AND, 8'h0F, 8'h3C);
        expect_rsp(1'b0, 8'h0C, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_valid",  {31'd0, bus.rsp_valid}, 32'd1);
            chk("hold_data",   {24'd0, bus.rsp_data},  32'h0FE);
            chk("hold_id",     {31'd0, bus.rsp_id},    32'd1);
            chk("hold_r0_rdy", {31'd0, bus.r0_ready},  32'd0);
            chk("hold_r1_rdy", {31'd0, bus.r1_ready},  32'd0);
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        wait_accept(1'b0, w);
        drive(1'b0, 1'b0, ALU_ADD, 8'h00, 8'h00);
        wait_drain();

        // MUL 13*11 = 143 = 8F, then 20*20 = 400 -> 90 with high bits set
        drive(1'b0, 1'b1, ALU_MUL, 8'd13, 8'd11);
        expect_rsp(1'b0, 8'h8F, 1'b0);
        wait_accept(1'b0, w);
        drive(1'b0, 1'b0, ALU_ADD, 8'h00, 8'h00);
        measure_lat(lat);
        chk("mul_latency", lat, 32'd9);
        wait_drain();

        drive(1'b0, 1'b1, ALU_MUL, 8'd20, 8'd20);
        expect_rsp(1'b0, 8'h90, 1'b1);
        wait_accept(1'b0, w);
        drive(1'b0, 1'b0, ALU_ADD, 8'h00, 8'h00);
        measure_lat(lat);
        chk("mul2_latency", lat, 32'd9);
        wait_drain();

        // Only r1 valid: granted immediately every time
        drive(1'b1, 1'b1, ALU_ADD, 8'h10, 8'h20);
        expect_rsp(1'b1, 8'h30, 1'b0);
        wait_accept(1'b1, w);
        chk("r1_only_wait0", w, 32'd1);
        drive(1'b1, 1'b0, ALU_ADD, 8'h00, 8'h00);
        wait_drain();
        drive(1'b1, 1'b1, ALU_AND, 8'hF0, 8'h3C);
        expect_rsp(1'b1, 8'h30, 1'b0);
        wait_accept(1'b1, w);
        chk("r1_only_wait1", w, 32'd1);
        drive(1'b1, 1'b0, ALU_ADD, 8'h00, 8'h00);
        wait_drain();
        drive(1'b1, 1'b1, ALU_SUB, 8'h00, 8'h01);
        expect_rsp(1'b1, 8'hFF, 1'b0);
        wait_accept(1'b1, w);
        chk("r1_only_wait2", w, 32'd1);
        drive(1'b1, 1'b0, ALU_ADD, 8'h00, 8'h00);
        wait_drain();

        // Both valid continuously: pointer now at r0, grants alternate
        drive(1'b0, 1'b1, ALU_AND, 8'hAA, 8'h0F);
        drive(1'b1, 1'b1, ALU_AND, 8'h55, 8'hF0);
        for (int i = 0; i < 4; i++) begin
            expect_rsp(i[0], (i[0] ? 8'h50 : 8'h0A), 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            seen = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (bus.r0_ready === 1'b1 || bus.r1_ready === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("alt_grant_seen", {31'd0, seen}, 32'd1);
            chk("alt_grant_id", {31'd0, bus.r1_ready}, {31'd0, i[0]});
            @(posedge clk);
            #1;
        end
        drive(1'b0, 1'b0, ALU_ADD, 8'h00, 8'h00);
        drive(1'b1, 1'b0, ALU_ADD, 8'h00, 8'h00);
        wait_drain();

        // Reset in the middle of a multiply aborts it without a response
        drive(1'b0, 1'b1, ALU_MUL, 8'd3, 8'd3);
        wait_accept(1'b0, w);
        drive(1'b0, 1'b0, ALU_ADD, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("abort_rst_data",  {24'd0, bus.rsp_data},  32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) seen = 1'b1;
        end
        chk("abort_no_rsp", {31'd0, seen}, 32'd0);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b1, ALU_ADD, 8'h01, 8'h02);
        expect_rsp(1'b1, 8'h03, 1'b0);
        wait_accept(1'b1, w);
        chk("abort_idle_accept", w, 32'd1);
        drive(1'b1, 1'b0, ALU_ADD, 8'h00, 8'h00);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
